// File: rtl/jtdd2_snd_pkg.sv
// Shared constants for the JTDD2 sound mixer: gain format, output range and clip hold default.
package jtdd2_snd_pkg;
    localparam int GAIN_W        = 8;
    localparam int FRAC_W        = 4;
    localparam int SND_W         = 16;
    localparam int SND_MAX       = 32767;
    localparam int SND_MIN       = -32768;
    localparam int CLIP_HOLD_DEF = 4095;
endpackage

// File: rtl/jtdd2_snd_sat.sv
// Saturating narrowing of a wide signed value to the 16-bit sound range, with overflow flag.
module jtdd2_snd_sat
    import jtdd2_snd_pkg::*;
#(
    parameter int IW = 25
) (
    input  logic signed [IW-1:0]    din,
    output logic signed [SND_W-1:0] dout,
    output logic                    ovf
);
    localparam logic signed [IW-1:0] MAX_W = IW'(SND_MAX);
    localparam logic signed [IW-1:0] MIN_W = IW'(SND_MIN);

    always_comb begin
        dout = SND_W'(din);
        ovf  = 1'b0;
        if (din > MAX_W) begin
            dout = SND_W'(SND_MAX);
            ovf  = 1'b1;
        end else if (din < MIN_W) begin
            dout = SND_W'(SND_MIN);
            ovf  = 1'b1;
        end
    end
endmodule

// File: rtl/jtdd2_snd_mix.sv
// JTDD2 sound mixer: FM + ADPCM gain/mix pipeline with saturation and clip hold.
// Optional DC-blocking output stage enabled by defining JTDD2_MIX_DCBLOCK_EN.
module jtdd2_snd_mix
    import jtdd2_snd_pkg::*;
#(
    parameter int CLIPW     = 12,
    parameter int CLIP_HOLD = CLIP_HOLD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen,
    input  logic signed [15:0]       fm_left,
    input  logic signed [15:0]       fm_right,
    input  logic signed [13:0]       adpcm,
    input  logic [GAIN_W-1:0]        fm_gain,
    input  logic [GAIN_W-1:0]        pcm_gain,
    output logic signed [SND_W-1:0]  sound,
    output logic                     sample,
    output logic                     clip
);
    logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [15:0]      fm1_q, fm1_d, pcm1_q, pcm1_d;
    logic [GAIN_W-1:0]       fg1_q, fg1_d, pg1_q, pg1_d;
    logic signed [23:0]      fmp2_q, fmp2_d, pcmp2_q, pcmp2_d;
    logic signed [SND_W-1:0] s3_q, s3_d;
    logic [CLIPW-1:0]        cnt_q, cnt_d;
    logic                    clip_q, clip_d;

    logic signed [16:0]      fm_sum;
    logic signed [24:0]      fm_prod, pcm_prod, mix_sum, mix_shr;
    logic signed [SND_W-1:0] sat3_out;
    logic                    sat3_ovf;

    jtdd2_snd_sat #(.IW(25)) u_sat3 (
        .din  (mix_shr),
        .dout (sat3_out),
        .ovf  (sat3_ovf)
    );

    always_comb begin
        // Stage 1: capture inputs only on cen; gains travel with their sample.
        fm_sum = 17'(fm_left) + 17'(fm_right);
        v1_d   = cen;
        fm1_d  = cen ? 16'(fm_sum >>> 1) : fm1_q;
        pcm1_d = cen ? {adpcm, 2'b00} : pcm1_q;
        fg1_d  = cen ? fm_gain : fg1_q;
        pg1_d  = cen ? pcm_gain : pg1_q;

        // Stage 2: gains are zero-extended so 0xFF stays positive.
        fm_prod  = 25'(fm1_q) * 25'($signed({1'b0, fg1_q}));
        pcm_prod = 25'(pcm1_q) * 25'($signed({1'b0, pg1_q}));
        v2_d     = v1_q;
        fmp2_d   = 24'(fm_prod);
        pcmp2_d  = 24'(pcm_prod);

        mix_sum = 25'(fmp2_q) + 25'(pcmp2_q);
        mix_shr = mix_sum >>> FRAC_W;
        v3_d    = v2_q;
        s3_d    = v2_q ? sat3_out : s3_q;

        // Reload on saturation takes priority over the cen-paced countdown.
        cnt_d = cnt_q;
        if (v2_q && sat3_ovf) begin
            cnt_d = CLIPW'(CLIP_HOLD);
        end else if (cen && (cnt_q != '0)) begin
            cnt_d = cnt_q - CLIPW'(1);
        end
        clip_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            fm1_q   <= '0;
            pcm1_q  <= '0;
            fg1_q   <= '0;
            pg1_q   <= '0;
            fmp2_q  <= '0;
            pcmp2_q <= '0;
            s3_q    <= '0;
            cnt_q   <= '0;
            clip_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            fm1_q   <= fm1_d;
            pcm1_q  <= pcm1_d;
            fg1_q   <= fg1_d;
            pg1_q   <= pg1_d;
            fmp2_q  <= fmp2_d;
            pcmp2_q <= pcmp2_d;
            s3_q    <= s3_d;
            cnt_q   <= cnt_d;
            clip_q  <= clip_d;
        end
    end

`ifdef JTDD2_MIX_DCBLOCK_EN
    logic                    v4_q, v4_d;
    logic signed [SND_W-1:0] x_prev_q, x_prev_d, y_q, y_d;
    logic signed [18:0]      dc_sum;
    logic signed [SND_W-1:0] dc_out;
    logic                    dc_ovf;

    jtdd2_snd_sat #(.IW(19)) u_sat_dc (
        .din  (dc_sum),
        .dout (dc_out),
        .ovf  (dc_ovf)
    );

    // Leaky differentiator: pole at 1 - 1/256 removes the DC component.
    always_comb begin
        dc_sum   = 19'(s3_q) - 19'(x_prev_q) + 19'(y_q) - 19'(y_q >>> 8);
        v4_d     = v3_q;
        y_d      = v3_q ? dc_out : y_q;
        x_prev_d = v3_q ? s3_q : x_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v4_q     <= 1'b0;
            y_q      <= '0;
            x_prev_q <= '0;
        end else begin
            v4_q     <= v4_d;
            y_q      <= y_d;
            x_prev_q <= x_prev_d;
        end
    end

    assign sound  = y_q;
    assign sample = v4_q;
`else
    assign sound  = s3_q;
    assign sample = v3_q;
`endif
    assign clip = clip_q;
endmodule

// File: tb/tb_jtdd2_snd_mix.sv
// Directed bench for jtdd2_snd_mix; expected sound values and arrival cycles are queued at drive time.
module tb_jtdd2_snd_mix;
    logic               clk = 1'b0;
    logic               rst;
    logic               cen;
    logic signed [15:0] fm_left, fm_right;
    logic signed [13:0] adpcm;
    logic [7:0]         fm_gain, pcm_gain;
    logic signed [15:0] sound;
    logic               sample, clip;

`ifdef JTDD2_MIX_DCBLOCK_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    int          xp = 0;
    int          yp = 0;

    jtdd2_snd_mix dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .fm_left  (fm_left),
        .fm_right (fm_right),
        .adpcm    (adpcm),
        .fm_gain  (fm_gain),
        .pcm_gain (pcm_gain),
        .sound    (sound),
        .sample   (sample),
        .clip     (clip)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat16(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int model(int fl, int fr, int a, int fg, int pg);
        int fm, pcm, y;
        fm  = (fl + fr) >>> 1;
        pcm = a * 4;
        y   = sat16((fm * fg + pcm * pg) >>> 4);
`ifdef JTDD2_MIX_DCBLOCK_EN
        begin
            int d;
            d  = sat16(y - xp + yp - (yp >>> 8));
            xp = y;
            yp = d;
            y  = d;
        end
`endif
        return y;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(int fl, int fr, int a, int fg, int pg);
        fm_left  = 16'(fl);
        fm_right = 16'(fr);
        adpcm    = 14'(a);
        fm_gain  = 8'(fg);
        pcm_gain = 8'(pg);
        cen      = 1'b1;
        exp_q.push_back(16'(model(fl, fr, a, fg, pg)));
        exp_cyc_q.push_back(cyc + LAT);
        @(negedge clk);
    endtask

    // Inputs wander randomly between cen pulses; the DUT must ignore them.
    task automatic idle(int n);
        cen = 1'b0;
        for (int i = 0; i < n; i++) begin
            fm_left  = 16'($urandom_range(0, 65535));
            fm_right = 16'($urandom_range(0, 65535));
            adpcm    = 14'($urandom_range(0, 16383));
            fm_gain  = 8'($urandom_range(0, 255));
            pcm_gain = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            idle(1);
            k++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        idle(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cen = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        xp = 0;
        yp = 0;
        repeat (2) @(negedge clk);
        chk("rst_sound", int'(sound), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_clip", int'(clip), 0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        logic [15:0] e;
        int          c;
        if (sample === 1'b1) begin
            chk("sample_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                chk("sound", int'(sound), int'($signed(e)));
                chk("latency", cyc, c);
            end
        end
    end

    initial begin
        rst = 1'b1; cen = 1'b0;
        fm_left = '0; fm_right = '0; adpcm = '0; fm_gain = '0; pcm_gain = '0;
        do_reset();

        drive(4096, 4096, 0, 16, 0);
        wait_drain("basic");
        chk("basic_clip", int'(clip), 0);

        drive(1000, 1000, 100, 255, 255);
        idle(1);
        drive(-1000, -1000, -100, 255, 255);
        drive(20000, 20000, 50, 0, 16);
        drive(-3, 2, 0, 16, 0);
        drive(-12345, 777, 4000, 8'h37, 8'h0c);
        wait_drain("gain");
        chk("gain_clip", int'(clip), 0);

        for (int k = 0; k < 8; k++) drive(0, 0, k, 0, 16);
        wait_drain("ramp");

        drive(0, 0, -8192, 0, 32);
        wait_drain("neg_sat");
        chk("neg_sat_clip", int'(clip), 1);
        do_reset();
        drive(0, 0, -8192, 0, 16);
        wait_drain("neg_edge");
        chk("neg_edge_clip", int'(clip), 0);

        do_reset();
        drive(32767, 32767, 0, 32, 0);
        wait_drain("pos_sat");
        chk("pos_sat_clip", int'(clip), 1);
        repeat (2000) drive(0, 0, 0, 16, 16);
        chk("clip_mid", int'(clip), 1);
        drive(32767, 32767, 0, 32, 0);
        wait_drain("reload");
        chk("reload_clip", int'(clip), 1);
        repeat (4094) drive(0, 0, 0, 16, 16);
        chk("clip_hold", int'(clip), 1);
        drive(0, 0, 0, 16, 16);
        chk("clip_clear", int'(clip), 0);
        wait_drain("clip_tail");

        do_reset();
        drive(4096, 4096, 0, 16, 0);
        rst = 1'b1;
        cen = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);
        chk("midrst_sound", int'(sound), 0);
        chk("midrst_sample", int'(sample), 0);

        rst = 1'b1;
        cen = 1'b1;
        fm_left = 16'sd20000; fm_right = 16'sd20000; fm_gain = 8'h10;
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        chk("rstcen_sound", int'(sound), 0);
        chk("rstcen_clip", int'(clip), 0);

`ifdef JTDD2_MIX_DCBLOCK_EN
        do_reset();
        repeat (6) drive(4096, 4096, 0, 16, 0);
        wait_drain("dcblock");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtdd2_snd_mix.md
JTDD2_SND_MIX -- requirements
Module: jtdd2_snd_mix

Interface
REQ-001 SHALL have parameter CLIPW, default 12, width of the clip-hold counter.
REQ-002 SHALL have parameter CLIP_HOLD, default 4095, number of cen pulses for which clip stays high after the last saturation.
REQ-003 SHALL have port clk, input, 1, the only clock (48 MHz system clock).
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port cen, input, 1, sample-rate enable; one new input sample is accepted per cen pulse.
REQ-006 SHALL have ports fm_left and fm_right, input, 16 each, signed FM channels.
REQ-007 SHALL have port adpcm, input, 14, signed ADPCM sample.
REQ-008 SHALL have ports fm_gain and pcm_gain, input, 8 each, unsigned 4.4 fixed-point gains (0x10 = 1.0).
REQ-009 SHALL have port sound, output, 16, signed mixed mono output.
REQ-010 SHALL have port sample, output, 1, single-clk pulse marking a new sound value.
REQ-011 SHALL have port clip, output, 1, saturation indicator.

Function
REQ-012 The datapath SHALL be a 3-stage pipeline with a valid bit per stage; stage 1 loads on cen, and every stage advances each clk.
REQ-013 Stage 1 SHALL register fm = (fm_left + fm_right) >>> 1 (17-bit sum, arithmetic shift) and pcm = adpcm sign-extended and shifted left by 2 (16 bits).
REQ-014 Stage 2 SHALL register fm*fm_gain and pcm*pcm_gain as signed 24-bit products; gains are treated as unsigned.
REQ-015 Stage 3 SHALL form a 25-bit sum, shift it right arithmetically by 4, saturate the result to [-32768, 32767], and register it to sound.
REQ-016 sound and sample SHALL update exactly 3 clk after the cen cycle; sample is high for exactly 1 clk.
REQ-017 Back-to-back cen pulses (every clk) SHALL each produce one output, with no sample dropped.
REQ-018 Gain 0x00 SHALL contribute exactly 0; gain 0xFF SHALL be 15.9375x without wrap.
REQ-019 Any stage-3 saturation SHALL set clip and load the hold counter with CLIP_HOLD; the counter decrements on cen and clip clears when it reaches 0.
REQ-020 A new saturation while clip is held SHALL reload the counter.
REQ-021 Inputs SHALL be sampled only in cen cycles; changes between cen pulses are ignored.

Reset
REQ-022 While rst is high: sound=0, sample=0, clip=0, all valid bits=0, hold counter=0.
REQ-023 Asserting rst mid-pipeline SHALL discard in-flight samples, so no sample pulse follows the reset.
REQ-024 cen received in the same cycle as rst SHALL be ignored.

Configuration
REQ-025 With macro JTDD2_MIX_DCBLOCK_EN defined, a 4th registered stage SHALL apply y = x - x_prev + y_prev - (y_prev >>> 8), saturated to 16 bits, updated once per valid sample; latency becomes 4 clk; x_prev and y_prev reset to 0.
REQ-026 Without JTDD2_MIX_DCBLOCK_EN, there SHALL be no 4th stage, latency is 3 clk, and no DC-block state exists.

Structure
REQ-027 Package jtdd2_snd_pkg SHALL hold the gain width (8), the fractional-bit count (4), SND_MAX/SND_MIN (32767/-32768) and the default CLIP_HOLD.
REQ-028 Saturating narrowing (wide signed to 16 bits, plus overflow flag) SHALL be the sub-module jtdd2_snd_sat, used by stage 3 and the DC-block stage.

Verification
REQ-029 fm_left=fm_right=16'h1000, adpcm=0, fm_gain=8'h10, one cen -> sound=4096 and a 1-clk sample 3 clk later; clip=0.
REQ-030 fm_left=fm_right=32767, fm_gain=8'h20, pcm_gain=0 -> sound=32767, clip=1; clip stays high for 4095 further cen pulses, then clears.
REQ-031 adpcm=-8192, pcm_gain=8'h20, fm_gain=0 -> sound=-32768, clip=1; with pcm_gain=8'h10 -> sound=-32768, clip=0.
REQ-032 cen held high for 8 clk with a ramping adpcm (0,1,...,7), pcm_gain=8'h10 -> 8 consecutive sample pulses, sound=0,4,...,28.
REQ-033 rst asserted 1 clk after cen -> no sample pulse; sound remains 0.
REQ-034 Run with JTDD2_MIX_DCBLOCK_EN defined, a constant fm input of 4096 at gain 8'h10 -> first output 4096, then decaying toward 0 (second output 4080); latency 4 clk.
